// File: rtl/icache_direct_if.sv
// Fetch/refill bus of the direct-mapped instruction cache.
//   slave  : the cache side (takes fetch requests and refill data,
//            drives responses and refill requests)
//   master : the environment side (ifetch + memory controller)
// Signals:
//   if2cache_req/PC/flush  fetch request, address, redirect
//   cache2if_valid/inst/PC returned instruction (one-cycle pulse)
//   cache_busy             a miss is in progress
//   cache2mem_upd_en/PC    refill request and address
//   mem2cache_upd/inst     refill-complete pulse and data
interface icache_direct_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  if2cache_req;
  logic [ADDR_WIDTH-1:0] if2cache_PC;
  logic                  if2cache_flush;
  logic                  cache2if_valid;
  logic [INST_WIDTH-1:0] cache2if_inst;
  logic [ADDR_WIDTH-1:0] cache2if_PC;
  logic                  cache_busy;
  logic                  cache2mem_upd_en;
  logic [ADDR_WIDTH-1:0] cache2mem_PC;
  logic                  mem2cache_upd;
  logic [INST_WIDTH-1:0] mem2cache_inst;

  modport slave (
    input  if2cache_req, if2cache_PC, if2cache_flush, mem2cache_upd, mem2cache_inst,
    output cache2if_valid, cache2if_inst, cache2if_PC, cache_busy,
           cache2mem_upd_en, cache2mem_PC
  );

  modport master (
    output if2cache_req, if2cache_PC, if2cache_flush, mem2cache_upd, mem2cache_inst,
    input  cache2if_valid, cache2if_inst, cache2if_PC, cache_busy,
           cache2mem_upd_en, cache2mem_PC
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, one instruction word per line, indexed
// by the halfword-aligned PC so compressed instructions get their own lines.
// Hits return one cycle after the request; misses issue a single-word refill
// and forward the refilled word unless a redirect arrived meanwhile.
// Ports:
//   clk     clock, all state on posedge
//   rst_in  synchronous active-low reset
//   rdy_in  global ready; 0 freezes all state and outputs
//   bus     icache_direct_if.slave (fetch and refill signals)
module icache_direct #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32,
  parameter int INDEX_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_in,
  input  logic               rdy_in,
  icache_direct_if.slave     bus
);
  localparam int NUM   = 1 << INDEX_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                r_state, w_nxt;
  logic [NUM-1:0]        r_valid;
  logic [TAG_W-1:0]      r_tag  [NUM];
  logic [INST_WIDTH-1:0] r_data [NUM];
  logic                  r_out_valid;
  logic [INST_WIDTH-1:0] r_out_inst;
  logic [ADDR_WIDTH-1:0] r_out_pc;
  logic [ADDR_WIDTH-1:0] r_mem_pc;
  logic                  r_drop;      // redirect seen while waiting: drop the fill pulse

  logic [INDEX_WIDTH-1:0] w_idx, w_fill_idx;
  logic [TAG_W-1:0]       w_tag, w_fill_tag;
  logic w_accept, w_hit, w_hit_ok, w_miss, w_fill, w_busy, w_upd_en;
  logic w_unused;

  // PC bit 0 is always zero and never takes part in lookup.
  assign w_unused = bus.if2cache_PC[0];

  always_comb begin
    w_idx      = bus.if2cache_PC[INDEX_WIDTH:1];
    w_tag      = bus.if2cache_PC[ADDR_WIDTH-1:INDEX_WIDTH+1];
    w_fill_idx = r_mem_pc[INDEX_WIDTH:1];
    w_fill_tag = r_mem_pc[ADDR_WIDTH-1:INDEX_WIDTH+1];
    w_accept   = bus.if2cache_req && !bus.if2cache_flush;
    w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    w_nxt      = r_state;
    w_hit_ok   = 1'b0;
    w_miss     = 1'b0;
    w_fill     = 1'b0;
    w_busy     = 1'b0;
    w_upd_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_hit) w_hit_ok = 1'b1;
          else begin
            w_miss = 1'b1;
            w_nxt  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_busy   = 1'b1;
        // Dropped combinationally on the completion cycle so the controller
        // never sees a second refill request on that edge.
        w_upd_en = !bus.mem2cache_upd;
        if (bus.mem2cache_upd) begin
          w_fill = 1'b1;
          w_nxt  = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_in)     r_state <= S_IDLE;
    else if (rdy_in) r_state <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      r_valid     <= '0;
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_pc    <= '0;
      r_mem_pc    <= '0;
      r_drop      <= 1'b0;
    end else if (rdy_in) begin
      r_out_valid <= 1'b0;
      if (w_hit_ok) begin
        r_out_valid <= 1'b1;
        r_out_inst  <= r_data[w_idx];
        r_out_pc    <= bus.if2cache_PC;
      end
      if (w_miss) begin
        r_mem_pc <= bus.if2cache_PC;
        r_drop   <= 1'b0;
      end
      if (r_state == S_WAIT && bus.if2cache_flush) r_drop <= 1'b1;
      if (w_fill) begin
        // The line is installed even when the response itself is dropped.
        r_valid[w_fill_idx] <= 1'b1;
        if (!r_drop && !bus.if2cache_flush) begin
          r_out_valid <= 1'b1;
          r_out_inst  <= bus.mem2cache_inst;
          r_out_pc    <= r_mem_pc;
        end
      end
    end
  end

  // Tag/data storage needs no reset: the valid bits guard it.
  always_ff @(posedge clk) begin
    if (rst_in && rdy_in && w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= bus.mem2cache_inst;
    end
  end

  assign bus.cache2if_valid   = r_out_valid;
  assign bus.cache2if_inst    = r_out_inst;
  assign bus.cache2if_PC      = r_out_pc;
  assign bus.cache_busy       = w_busy;
  assign bus.cache2mem_upd_en = w_upd_en;
  assign bus.cache2mem_PC     = r_mem_pc;
endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;
  localparam int AW = 32, IW = 32, XW = 5, NL = 1 << XW;

  logic clk = 1'b0, rst_in = 1'b0, rdy_in = 1'b1;
  always #5 clk = ~clk;

  icache_direct_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();
  icache_direct #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .INDEX_WIDTH(XW)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference: each line remembers the full PC it holds (idx+tag == PC[31:1]).
  bit          m_v  [NL];
  logic [31:0] m_pc [NL];
  logic [31:0] m_d  [NL];

  function automatic int lidx(input logic [31:0] pc);
    return int'((pc >> 1) % NL);
  endfunction

  function automatic logic [31:0] memw(input logic [31:0] pc);
    if (pc == 32'h0)  return 32'h0000_0513;
    if (pc == 32'h44) return 32'hDEAD_BEEF;
    return pc * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_rst_outs(input string p);
    chk({p, "_busy"},  {31'd0, bus.cache_busy},       32'd0);
    chk({p, "_upd"},   {31'd0, bus.cache2mem_upd_en}, 32'd0);
    chk({p, "_vld"},   {31'd0, bus.cache2if_valid},   32'd0);
    chk({p, "_inst"},  bus.cache2if_inst,             32'd0);
    chk({p, "_pc"},    bus.cache2if_PC,               32'd0);
    chk({p, "_mpc"},   bus.cache2mem_PC,              32'd0);
  endtask

  // One fetch transaction. fl: 0 none, 1 flush mid-wait, 2 flush with completion.
  // stall: hold rdy_in low 3 cycles during the wait and at the response pulse.
  task automatic fetch(input logic [31:0] pc, input int lat, input int fl, input bit stall);
    int  li  = lidx(pc);
    bit  hit = m_v[li] && (m_pc[li] == pc);
    bit  pulse;
    logic [31:0] exp_d;
    bus.if2cache_req = 1'b1;
    bus.if2cache_PC  = pc;
    cyc();
    bus.if2cache_req = 1'b0;
    if (hit) begin
      pulse = 1'b1;
      exp_d = m_d[li];
      chk("hit_upd_en", {31'd0, bus.cache2mem_upd_en}, 32'd0);
      chk("hit_busy",   {31'd0, bus.cache_busy},       32'd0);
    end else begin
      chk("miss_busy",   {31'd0, bus.cache_busy},       32'd1);
      chk("miss_upd_en", {31'd0, bus.cache2mem_upd_en}, 32'd1);
      chk("miss_pc",     bus.cache2mem_PC,              pc);
      chk("miss_novld",  {31'd0, bus.cache2if_valid},   32'd0);
      for (int i = 0; i < lat; i++) begin
        if (stall && i == 0) begin
          rdy_in = 1'b0;
          repeat (3) begin
            cyc();
            chk("frz_busy", {31'd0, bus.cache_busy},       32'd1);
            chk("frz_upd",  {31'd0, bus.cache2mem_upd_en}, 32'd1);
            chk("frz_pc",   bus.cache2mem_PC,              pc);
          end
          rdy_in = 1'b1;
        end
        if (fl == 1 && i == lat / 2) bus.if2cache_flush = 1'b1;
        cyc();
        bus.if2cache_flush = 1'b0;
        chk("wait_upd_en", {31'd0, bus.cache2mem_upd_en}, 32'd1);
        chk("wait_pc",     bus.cache2mem_PC,              pc);
      end
      bus.mem2cache_upd  = 1'b1;
      bus.mem2cache_inst = memw(pc);
      if (fl == 2 || (fl == 1 && lat == 0)) bus.if2cache_flush = 1'b1;
      #1 chk("upd_en_drop", {31'd0, bus.cache2mem_upd_en}, 32'd0);
      cyc();
      bus.mem2cache_upd  = 1'b0;
      bus.mem2cache_inst = 32'h0;
      bus.if2cache_flush = 1'b0;
      m_v[li]  = 1'b1;
      m_pc[li] = pc;
      m_d[li]  = memw(pc);
      pulse = (fl == 0);
      exp_d = memw(pc);
      chk("fill_busy", {31'd0, bus.cache_busy}, 32'd0);
    end
    chk("resp_vld", {31'd0, bus.cache2if_valid}, {31'd0, pulse});
    if (pulse) begin
      chk("resp_inst", bus.cache2if_inst, exp_d);
      chk("resp_pc",   bus.cache2if_PC,   pc);
      if (stall) begin
        rdy_in = 1'b0;
        repeat (3) begin
          cyc();
          chk("frz_vld",  {31'd0, bus.cache2if_valid}, 32'd1);
          chk("frz_inst", bus.cache2if_inst,           exp_d);
        end
        rdy_in = 1'b1;
      end
    end
    cyc();
    chk("pulse_end", {31'd0, bus.cache2if_valid}, 32'd0);
  endtask

  initial begin
    bus.if2cache_req   = 1'b0;
    bus.if2cache_PC    = '0;
    bus.if2cache_flush = 1'b0;
    bus.mem2cache_upd  = 1'b0;
    bus.mem2cache_inst = '0;
    for (int i = 0; i < NL; i++) m_v[i] = 1'b0;
    @(negedge clk);
    repeat (2) cyc();
    chk_rst_outs("rst");
    rst_in = 1'b1;
    cyc();

    fetch(32'h0,  4, 0, 1'b0);   // cold miss
    fetch(32'h0,  0, 0, 1'b0);   // hit
    fetch(32'h4,  2, 0, 1'b0);
    fetch(32'h44, 3, 0, 1'b0);   // evicts 0x4
    fetch(32'h4,  1, 0, 1'b0);   // misses again
    fetch(32'h2,  2, 0, 1'b0);   // halfword line
    fetch(32'h0,  0, 0, 1'b0);   // still hits
    fetch(32'h100, 3, 1, 1'b0);  // flushed miss, no pulse
    fetch(32'h100, 0, 0, 1'b0);  // installed anyway

    // Flush alongside a hit request rejects it.
    bus.if2cache_req = 1'b1; bus.if2cache_PC = 32'h100; bus.if2cache_flush = 1'b1;
    cyc();
    bus.if2cache_req = 1'b0; bus.if2cache_flush = 1'b0;
    chk("flush_hit_vld",  {31'd0, bus.cache2if_valid}, 32'd0);
    chk("flush_hit_busy", {31'd0, bus.cache_busy},     32'd0);

    fetch(32'h200, 2, 2, 1'b0);  // flush on completion cycle
    fetch(32'h300, 3, 0, 1'b1);  // freeze in wait and at pulse
    fetch(32'h300, 0, 0, 1'b1);  // freeze at hit pulse

    // Reset in the middle of a miss.
    bus.if2cache_req = 1'b1; bus.if2cache_PC = 32'h42;
    cyc();
    bus.if2cache_req = 1'b0;
    cyc();
    rst_in = 1'b0;
    cyc();
    chk_rst_outs("midrst");
    rst_in = 1'b1;
    for (int i = 0; i < NL; i++) m_v[i] = 1'b0;
    fetch(32'h300, 2, 0, 1'b0);  // previously a hit, now misses

    for (int n = 0; n < 60; n++) begin
      int r = $urandom_range(0, 9);
      fetch({23'd0, 8'($urandom_range(0, 127)), 1'b0}, $urandom_range(0, 4),
            (r == 0) ? 1 : (r == 1) ? 2 : 0, $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped instruction cache between the instruction-fetch stage and the memory controller. It serves fetch requests from ifetch. On a hit it returns the 32-bit instruction word one cycle after the request. On a miss it issues a single-word refill request to the memory controller, waits for the controller's completion pulse, installs the word, and forwards it to ifetch. Lines are one instruction word each, indexed by halfword-aligned PC, so compressed (16-bit) instructions are supported.

## Interface
- ADDR_WIDTH, 32, PC width
- INST_WIDTH, 32, instruction word width
- INDEX_WIDTH, 5, index bits; the cache has 2^INDEX_WIDTH entries
- clk  input  1  clock; all state updates on posedge
- rst_in  input  1  reset, synchronous and active-low (0 = reset)
- rdy_in  input  1  global ready; when 0, all state freezes and outputs hold
- if2cache_req  input  1  fetch request strobe
- if2cache_PC  input  ADDR_WIDTH  fetch address; bit 0 is always 0
- if2cache_flush  input  1  fetch redirect; kills the pending/accepted request
- cache2if_valid  output  1  one-cycle pulse; the instruction is valid
- cache2if_inst  output  INST_WIDTH  returned instruction
- cache2if_PC  output  ADDR_WIDTH  PC of the returned instruction
- cache_busy  output  1  a miss is in progress; requests are not accepted
- cache2mem_upd_en  output  1  refill request to the memory controller
- cache2mem_PC  output  ADDR_WIDTH  refill address
- mem2cache_upd  input  1  refill-complete pulse from the memory controller
- mem2cache_inst  input  INST_WIDTH  refill data, valid while mem2cache_upd=1

## Operation
- Address split:
  - idx = PC[INDEX_WIDTH:1]
  - tag = PC[ADDR_WIDTH-1:INDEX_WIDTH+1]
- Storage per entry: valid bit, tag, INST_WIDTH data word.
- Reset (rst_in=0 at posedge):
  - All valid bits are cleared; state goes to IDLE; the drop flag is cleared.
  - All outputs are 0 (cache_busy=0, cache2mem_upd_en=0, cache2if_valid=0, cache2if_inst=0, cache2if_PC=0, cache2mem_PC=0).
  - Reset has priority over rdy_in and over any in-flight miss. The miss is abandoned and nothing is written.
- State IDLE:
  - Request accepted when if2cache_req=1 and if2cache_flush=0.
  - Hit (valid[idx] and tag match): register the data and PC, pulse cache2if_valid next cycle, stay in IDLE.
  - Miss: latch the PC into cache2mem_PC, go to WAIT, clear the drop flag.
- State WAIT:
  - cache_busy=1.
  - cache2mem_upd_en = (state==WAIT) && !mem2cache_upd. This is combinational, so the controller cannot re-arm a second refill on the completion edge.
  - if2cache_req is ignored.
  - if2cache_flush=1 sets the drop flag.
  - On mem2cache_upd=1:
    - Write data, tag and valid at the idx of the latched PC.
    - Go to IDLE.
    - Pulse cache2if_valid next cycle with mem2cache_inst and the latched PC, unless the drop flag is set or flush is asserted in the same cycle.
- Flush never invalidates lines. A refill always installs, even if flushed.
- A request to the same idx with a different tag evicts the old entry on refill.
- cache2if_valid is a single-cycle pulse. With rdy_in=0 it holds its value until the next cycle in which rdy_in=1.

## Timing
- Hit latency: 1 cycle, from the request edge to cache2if_valid high.
- Miss latency: 1 cycle to assert upd_en, plus the memory time until mem2cache_upd, plus 1 cycle to cache2if_valid. Throughput on hits: one request per cycle.
- Back-to-back hits are allowed in IDLE. The cycle after returning from WAIT to IDLE may accept a new request at the same time as the fill response pulses.
- A request in the same cycle as mem2cache_upd is ignored (busy=1 that cycle). Ifetch must re-issue it.
- A flush in the same cycle as a hit request rejects the request; no pulse follows.
- A refill and an accepted hit to the same idx cannot overlap: fills occur only in WAIT.
- cache2mem_PC is stable for the whole WAIT period.

## Test plan
- Reset, then request PC=0x0000_0000 (cold miss):
  - cache2mem_upd_en=1 next cycle with cache2mem_PC=0.
  - Memory returns mem2cache_inst=0x0000_0513 after 4 cycles.
  - cache2if_valid pulses once with 0x0000_0513 and PC 0.
  - upd_en drops in the same cycle as mem2cache_upd.
- Re-request PC=0: valid pulses 1 cycle later with 0x0000_0513; upd_en stays 0.
- Conflict eviction:
  - Fill PC=0x0000_0004, then request PC=0x0000_0044 (same idx 2, different tag): this misses and refills with 0xDEAD_BEEF.
  - Re-request 0x04: it misses again.
- Halfword PC=0x0000_0002: misses and refills independently of PC=0x0; a later request to PC=0 still hits.
- Flush during WAIT for PC=0x100:
  - No cache2if_valid pulse.
  - A subsequent request to 0x100 hits in 1 cycle with the refilled data.
- Freeze and reset mid-miss:
  - rdy_in=0 for 3 cycles during WAIT and at a hit pulse: state and outputs hold and the pulse is emitted exactly once.
  - rst_in=0 mid-miss: all outputs are 0 next cycle and the previously hit PC now misses.
